// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART echo driver: bus register addresses, the
// driver FSM state type and the baud divisor helper.
//
// Contents:
//   IOADDR_DATA / IOADDR_STATUS / IOADDR_DB_LO / IOADDR_DB_HI  register map
//   drv_state_t                                                driver FSM states
//   baud_div(clk_hz, base, sel)                                divisor for rate base<<sel
// -----------------------------------------------------------------------------
package spart_pkg;

   localparam logic [1:0] IOADDR_DATA   = 2'b00;
   localparam logic [1:0] IOADDR_STATUS = 2'b01;
   localparam logic [1:0] IOADDR_DB_LO  = 2'b10;
   localparam logic [1:0] IOADDR_DB_HI  = 2'b11;

   typedef enum logic [2:0] {
      ST_CFG_LO = 3'd0,
      ST_CFG_HI = 3'd1,
      ST_IDLE   = 3'd2,
      ST_RX_RD  = 3'd3,
      ST_TX_WR  = 3'd4
   } drv_state_t;

   // Divisor for the SPART baud generator: clk_hz / (base << sel) - 1,
   // integer-truncated. Only ever called with constant arguments so it
   // folds away at elaboration.
   function automatic logic [15:0] baud_div(input int unsigned clk_hz,
                                            input int unsigned base,
                                            input logic [1:0]  sel);
      int unsigned rate;
      rate = base << sel;
      return 16'(clk_hz / rate - 1);
   endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// -----------------------------------------------------------------------------
// spart_drv_fifo
// Synchronous count-based FIFO with a first-word-fall-through head. Pushes
// while full and pops while empty are ignored, so pointers never wrap wrongly.
//
// Parameters: WIDTH data width, DEPTH entries (power of 2, >= 2)
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write strobe and data
//   pop         read strobe; dout shows the head before the pop
//   dout        current head entry
//   full, empty status flags
//   count       number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module spart_drv_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count define validity,
   // which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spart_echo_driver.sv
// -----------------------------------------------------------------------------
// spart_echo_driver
// Bus master for the SPART peripheral. After reset (or any change of br_cfg)
// it writes the 16-bit baud divisor to DB low/high, then echoes every byte
// received: reads from DATA into a FIFO whenever rda is set and space exists,
// and writes the FIFO head back to DATA whenever tbr is set. Reception has
// priority; an IDLE cycle separates every bus access so rda/tbr can settle.
//
// Build option: define SPART_ECHO_UPCASE_EN to convert 'a'..'z' to 'A'..'Z'
// as bytes enter the FIFO; otherwise bytes are echoed verbatim.
//
// Parameters: CLK_FREQ_HZ, BASE_BAUD (rate at br_cfg=0), FIFO_DEPTH
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   br_cfg       baud select, rate = BASE_BAUD << br_cfg
//   rda, tbr     SPART receive-available / transmit-ready
//   iocs, iorw   bus chip select, 1=read 0=write
//   ioaddr       register address
//   databus      bidirectional data, driven only on writes
//   cfg_done     divisor programmed for the current br_cfg
//   fifo_count   bytes buffered
//   rx_stall     rda pending while the FIFO is full
// -----------------------------------------------------------------------------
module spart_echo_driver
   import spart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned BASE_BAUD   = 4800,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    br_cfg,
   input  logic                          rda,
   input  logic                          tbr,
   output logic                          iocs,
   output logic                          iorw,
   output logic [1:0]                    ioaddr,
   inout  wire  [7:0]                    databus,
   output logic                          cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          rx_stall
);

   localparam logic [15:0] DIV_0 = baud_div(CLK_FREQ_HZ, BASE_BAUD, 2'd0);
   localparam logic [15:0] DIV_1 = baud_div(CLK_FREQ_HZ, BASE_BAUD, 2'd1);
   localparam logic [15:0] DIV_2 = baud_div(CLK_FREQ_HZ, BASE_BAUD, 2'd2);
   localparam logic [15:0] DIV_3 = baud_div(CLK_FREQ_HZ, BASE_BAUD, 2'd3);

   drv_state_t  state;
   drv_state_t  state_nxt;
   logic [1:0]  br_q;
   logic        br_change;
   logic [15:0] div_sel;
   logic [7:0]  wdata;
   logic [7:0]  push_data;
   logic [7:0]  fifo_head;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;

   assign br_change = (br_cfg != br_q);

   always_comb begin
      case (br_q)
         2'd0:    div_sel = DIV_0;
         2'd1:    div_sel = DIV_1;
         2'd2:    div_sel = DIV_2;
         default: div_sel = DIV_3;
      endcase
   end

   // State register, baud-select tracking and configuration flag. br_q
   // loads br_cfg during reset so a reset never looks like a br_cfg change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CFG_LO;
         br_q     <= br_cfg;
         cfg_done <= 1'b0;
      end else begin
         state <= state_nxt;
         br_q  <= br_cfg;
         if (br_change) begin
            cfg_done <= 1'b0;
         end else if (state == ST_CFG_HI) begin
            cfg_done <= 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      iocs      = 1'b0;
      iorw      = 1'b1;
      ioaddr    = IOADDR_DATA;
      wdata     = 8'h00;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;

      case (state)
         ST_CFG_LO: begin
            iocs      = 1'b1;
            iorw      = 1'b0;
            ioaddr    = IOADDR_DB_LO;
            wdata     = div_sel[7:0];
            state_nxt = ST_CFG_HI;
         end
         ST_CFG_HI: begin
            iocs      = 1'b1;
            iorw      = 1'b0;
            ioaddr    = IOADDR_DB_HI;
            wdata     = div_sel[15:8];
            state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (rda && !fifo_full) begin
               state_nxt = ST_RX_RD;
            end else if (tbr && !fifo_empty) begin
               state_nxt = ST_TX_WR;
            end
         end
         ST_RX_RD: begin
            iocs      = 1'b1;
            iorw      = 1'b1;
            ioaddr    = IOADDR_DATA;
            fifo_push = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_TX_WR: begin
            iocs      = 1'b1;
            iorw      = 1'b0;
            ioaddr    = IOADDR_DATA;
            wdata     = fifo_head;
            fifo_pop  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_CFG_LO;
      endcase

      // A new baud selection restarts configuration from any state; the
      // push/pop of an access already on the bus still completes.
      if (br_change) begin
         state_nxt = ST_CFG_LO;
      end
   end

   assign databus = (iocs && !iorw) ? wdata : 8'hzz;

`ifdef SPART_ECHO_UPCASE_EN
   assign push_data = (databus >= 8'h61 && databus <= 8'h7A) ? (databus - 8'h20) : databus;
`else
   assign push_data = databus;
`endif

   spart_drv_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (push_data),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rx_stall = rda && fifo_full;

endmodule

// File: tb/tb_spart_echo_driver.sv
// -----------------------------------------------------------------------------
// tb_spart_echo_driver
// Directed bench for spart_echo_driver. Acts as the SPART: supplies rda/tbr
// and drives databus while the driver reads. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spart_echo_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] br_cfg;
   logic       rda;
   logic       tbr;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       cfg_done;
   logic [3:0] fifo_count;
   logic       rx_stall;
   logic [7:0] rx_byte;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

   spart_echo_driver #(
      .CLK_FREQ_HZ (50_000_000),
      .BASE_BAUD   (4800),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_count (fifo_count),
      .rx_stall   (rx_stall)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One SPART receive: rda for the IDLE->RX_RD step, then dropped.
   task automatic do_rx(input logic [7:0] b, input logic [3:0] cnt_before);
      rx_byte = b;
      rda     = 1'b1;
      tick();
      check("rx_iocs", 16'(iocs), 16'd1);
      check("rx_iorw", 16'(iorw), 16'd1);
      check("rx_addr", 16'(ioaddr), 16'd0);
      rda = 1'b0;
      tick();
      check("rx_count", 16'(fifo_count), 16'(cnt_before + 4'd1));
   endtask

   // One SPART transmit slot: tbr for the IDLE->TX_WR step, then dropped.
   task automatic do_tx(input logic [7:0] exp, input logic [3:0] cnt_after);
      tbr = 1'b1;
      tick();
      check("tx_iocs", 16'(iocs), 16'd1);
      check("tx_iorw", 16'(iorw), 16'd0);
      check("tx_data", 16'(databus), 16'(exp));
      tbr = 1'b0;
      tick();
      check("tx_count", 16'(fifo_count), 16'(cnt_after));
   endtask

   initial begin
      logic [7:0] up61;
      logic [7:0] up7a;
`ifdef SPART_ECHO_UPCASE_EN
      up61 = 8'h41;
      up7a = 8'h5A;
`else
      up61 = 8'h61;
      up7a = 8'h7A;
`endif
      rst_n   = 1'b0;
      br_cfg  = 2'b00;
      rda     = 1'b0;
      tbr     = 1'b0;
      rx_byte = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_count", 16'(fifo_count), 16'd0);
      check("rst_cfg_done", 16'(cfg_done), 16'd0);
      check("rst_rx_stall", 16'(rx_stall), 16'd0);

      // 1: configuration with br_cfg=0, divisor 0x28AF
      rst_n = 1'b1;
      check("cfg0_lo_iocs", 16'(iocs), 16'd1);
      check("cfg0_lo_iorw", 16'(iorw), 16'd0);
      check("cfg0_lo_addr", 16'(ioaddr), 16'd2);
      check("cfg0_lo_data", 16'(databus), 16'hAF);
      tick();
      check("cfg0_hi_addr", 16'(ioaddr), 16'd3);
      check("cfg0_hi_data", 16'(databus), 16'h28);
      check("cfg0_hi_done", 16'(cfg_done), 16'd0);
      tick();
      check("cfg0_done", 16'(cfg_done), 16'd1);
      check("idle_iocs", 16'(iocs), 16'd0);
      check("idle_iorw", 16'(iorw), 16'd1);

      // 2: br_cfg 00->11, divisor 0x0515
      br_cfg = 2'b11;
      tick();
      check("cfg3_lo_addr", 16'(ioaddr), 16'd2);
      check("cfg3_lo_data", 16'(databus), 16'h15);
      check("cfg3_done_clr", 16'(cfg_done), 16'd0);
      tick();
      check("cfg3_hi_addr", 16'(ioaddr), 16'd3);
      check("cfg3_hi_data", 16'(databus), 16'h05);
      tick();
      check("cfg3_done", 16'(cfg_done), 16'd1);
      check("cfg3_count", 16'(fifo_count), 16'd0);

      // 3: single echo with rda and tbr both high
      rx_byte = 8'h41;
      rda     = 1'b1;
      tbr     = 1'b1;
      tick();
      check("e1_rd_iorw", 16'(iorw), 16'd1);
      check("e1_rd_count", 16'(fifo_count), 16'd0);
      rda = 1'b0;
      tick();
      check("e1_idle_iocs", 16'(iocs), 16'd0);
      check("e1_count1", 16'(fifo_count), 16'd1);
      tick();
      check("e1_wr_iorw", 16'(iorw), 16'd0);
      check("e1_wr_addr", 16'(ioaddr), 16'd0);
      check("e1_wr_data", 16'(databus), 16'h41);
      tbr = 1'b0;
      tick();
      check("e1_count0", 16'(fifo_count), 16'd0);

      // 4: fill to 8 with tbr low, 9th byte refused
      for (int i = 0; i < 8; i++) begin
         do_rx(8'h10 + 8'(i), 4'(i));
      end
      rx_byte = 8'h99;
      rda     = 1'b1;
      tick();
      check("full_iocs", 16'(iocs), 16'd0);
      check("full_stall", 16'(rx_stall), 16'd1);
      check("full_count", 16'(fifo_count), 16'd8);
      tick();
      check("full_iocs2", 16'(iocs), 16'd0);

      // Reconfiguration while full: br_cfg=01, divisor 0x1457, FIFO kept
      br_cfg = 2'b01;
      tick();
      check("cfg1_lo_data", 16'(databus), 16'h57);
      check("cfg1_done_clr", 16'(cfg_done), 16'd0);
      tick();
      check("cfg1_hi_data", 16'(databus), 16'h14);
      tick();
      check("cfg1_done", 16'(cfg_done), 16'd1);
      check("cfg1_count", 16'(fifo_count), 16'd8);
      check("cfg1_stall", 16'(rx_stall), 16'd1);
      rda = 1'b0;
      #1;
      check("stall_clr", 16'(rx_stall), 16'd0);

      // Drain in order with tbr held high
      tbr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("drain_iorw", 16'(iorw), 16'd0);
         check("drain_data", 16'(databus), 16'(8'h10 + 8'(i)));
         tick();
         check("drain_idle", 16'(iocs), 16'd0);
      end
      tbr = 1'b0;
      check("drain_count", 16'(fifo_count), 16'd0);

      // 5: RX priority over TX with FIFO non-empty
      do_rx(8'h55, 4'd0);
      rx_byte = 8'h66;
      rda     = 1'b1;
      tbr     = 1'b1;
      tick();
      check("prio_rd", 16'(iorw), 16'd1);
      rda = 1'b0;
      tick();
      check("prio_count2", 16'(fifo_count), 16'd2);
      tick();
      check("prio_wr1", 16'(databus), 16'h55);
      tick();
      check("prio_count1", 16'(fifo_count), 16'd1);
      tick();
      check("prio_wr2", 16'(databus), 16'h66);
      tbr = 1'b0;
      tick();
      check("prio_count0", 16'(fifo_count), 16'd0);

      // 6: case conversion boundaries
      do_rx(8'h61, 4'd0);
      do_tx(up61, 4'd0);
      do_rx(8'h7B, 4'd0);
      do_tx(8'h7B, 4'd0);
      do_rx(8'h7A, 4'd0);
      do_tx(up7a, 4'd0);
      do_rx(8'h60, 4'd0);
      do_tx(8'h60, 4'd0);

      // Reset with 3 bytes buffered
      do_rx(8'h31, 4'd0);
      do_rx(8'h32, 4'd1);
      do_rx(8'h33, 4'd2);
      rst_n = 1'b0;
      #1;
      check("mrst_count", 16'(fifo_count), 16'd0);
      check("mrst_done", 16'(cfg_done), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_iocs", 16'(iocs), 16'd1);
      check("mrst_addr", 16'(ioaddr), 16'd2);
      check("mrst_lo_data", 16'(databus), 16'h57);
      tick();
      check("mrst_hi_data", 16'(databus), 16'h14);
      tick();
      check("mrst_done2", 16'(cfg_done), 16'd1);
      check("mrst_count2", 16'(fifo_count), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
